// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes and FSM encodings for the multicycle multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_unsigned(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_div_restoring_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not borrow.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {rem_i, quo_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, div_i};

    always_comb begin
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU (radix-2 Booth) and DIV/DIVU (restoring) unit writing HI/LO,
// with a start/busy/done handshake toward the control unit.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH+1:0]   acc_q, acc_d;   // Booth accumulator / division remainder
    logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier / dividend-quotient shift register
    logic [WIDTH:0]     m_q, m_d;       // extended multiplicand / divisor magnitude
    logic               qm1_q, qm1_d;
    logic               uns_q, uns_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH+1:0]   m_ext, booth_sum, b_acc;
    logic [2*WIDTH+2:0] booth_sh;
    logic [WIDTH-1:0]   b_mq, hi_fix, d_rem, d_quo;
    logic               b_qm1, last;

    assign a_neg = !op_is_unsigned(op) && a[WIDTH-1];
    assign b_neg = !op_is_unsigned(op) && b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign last  = (cnt_q == CW'(WIDTH - 1));

    assign m_ext = {m_q[WIDTH], m_q};
    always_comb begin
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
    end
    assign booth_sh = $signed({booth_sum, mq_q, qm1_q}) >>> 1;
    assign b_acc    = booth_sh[2*WIDTH+2:WIDTH+1];
    assign b_mq     = booth_sh[WIDTH:1];
    assign b_qm1    = booth_sh[0];
    // After WIDTH steps qm1 holds b's MSB; for unsigned operands the implicit
    // zero above it yields one more +multiplicand digit at weight 2^WIDTH.
    assign hi_fix   = b_acc[WIDTH-1:0] + ((uns_q && b_qm1) ? m_q[WIDTH-1:0] : '0);

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q[WIDTH-1:0]),
        .quo_i (mq_q),
        .div_i (m_q[WIDTH-1:0]),
        .rem_o (d_rem),
        .quo_o (d_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        uns_d   = uns_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    uns_d = op_is_unsigned(op);
                    if (op_is_div(op) && (b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else if (op_is_div(op)) begin
                        dz_d    = 1'b0;
                        state_d = ST_DIV;
                        mq_d    = a_mag;
                        m_d     = {1'b0, b_mag};
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_MUL;
                        mq_d    = b;
                        m_d     = {a[WIDTH-1] && !op_is_unsigned(op), a};
                    end
                end
            end
            ST_MUL: begin
                acc_d = b_acc;
                mq_d  = b_mq;
                qm1_d = b_qm1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = hi_fix;
                    lo_d    = b_mq;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_DIV: begin
                acc_d = {2'b00, d_rem};
                mq_d  = d_quo;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    lo_d    = negq_q ? -d_quo : d_quo;
                    hi_d    = negr_q ? -d_rem : d_rem;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            uns_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            uns_q   <= uns_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a negedge
// monitor pops and compares them whenever done is seen.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        int           blen;
    } exp_t;

    exp_t         sbq[$];
    int           total = 0, bad = 0, cyc = 0, busy_len = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the architectural HI/LO state.
    task automatic predict(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output exp_t e);
        longint      sx, sy;
        logic [63:0] p;
        int          ix, iy;
        e.dz   = 1'b0;
        e.blen = W;
        e.cyc  = cyc + W + 1;
        case (o)
            MULT: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p = 64'(sx * sy);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    e.dz   = 1'b1;
                    e.blen = 0;
                    e.cyc  = cyc + 1;
                end else if (o == DIVU) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = x;
                    m_hi = '0;
                end else begin
                    ix = $signed(x);
                    iy = $signed(y);
                    m_lo = ix / iy;
                    m_hi = ix % iy;
                end
            end
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    task automatic issue_now(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        predict(o, x, y, e);
        sbq.push_back(e);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        issue_now(o, x, y);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (sbq.size() == 0) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL wait_idle: %0d responses outstanding, expected 0", sbq.size());
        sbq.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                chk("busy_at_done", busy, 0);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1, expected no response");
                end else begin
                    e = sbq.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("div_zero", div_zero, e.dz);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_len", busy_len, e.blen);
                end
                busy_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   o;
        logic [W-1:0] x, y;
        bit           seen;
        reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;

        // Directed cases
        issue(MULT, 32'hFFFF_FFFD, 32'd7); wait_idle();
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFEB);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        chk("t2u_hi", hi, 32'hFFFF_FFFE);
        chk("t2u_lo", lo, 32'h0000_0001);
        issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        issue(DIV, 32'hFFFF_FFF9, 32'd2); wait_idle();
        chk("t3a_lo", lo, 32'hFFFF_FFFD);
        chk("t3a_hi", hi, 32'hFFFF_FFFF);
        issue(DIVU, 32'd7, 32'd2); wait_idle();
        issue(DIV, 32'd7, 32'hFFFF_FFFE); wait_idle();
        chk("t3c_lo", lo, 32'hFFFF_FFFD);
        chk("t3c_hi", hi, 32'd1);

        issue(DIV, 32'd5, 32'd0); wait_idle();
        chk("t4_hi_kept", hi, 32'd1);
        chk("t4_lo_kept", lo, 32'hFFFF_FFFD);
        repeat (3) @(negedge clk);
        chk("t4_dz_hold", div_zero, 1);
        issue(MULT, 32'd3, 32'd4);
        chk("t4_dz_clear", div_zero, 0);
        wait_idle();

        // Overflow divide, then a start presented in its done cycle
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("t5_done_seen", seen, 1);
        chk("t5_lo", lo, 32'h8000_0000);
        chk("t5_hi", hi, 32'h0);
        issue_now(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("t5_b2b_busy", busy, 1);
        wait_idle();

        // Start while busy must be ignored
        issue(MULT, 32'hDEAD_BEEF, 32'h0000_0013);
        repeat (5) @(negedge clk);
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1; op = MULT; a = 32'h7654_3210; b = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);

        // Randomized operations with corner operands mixed in
        for (int n = 0; n < 48; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: y = 32'($urandom_range(1, 15));
                4: x = 32'($urandom_range(0, 3));
                default: ;
            endcase
            issue(o, x, y);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
